// File: rtl/debounce_edge.sv
// debounce_edge: input debouncer with registered level and edge-pulse outputs.
// Raw din is registered (one or two stages) into din_s, then a four-state FSM
// requires STABLE_CYCLES consecutive samples at a new level before dout follows.
// rise/fall pulse for exactly one cycle, in the cycle dout changes.
// Build option: define DEBOUNCE_SYNC_EN for a two-flop synchronizer on an
// asynchronous din; leave it undefined for a single register on an
// already-synchronous din.
module debounce_edge #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic [1:0] {
        ST_LOW      = 2'd0,
        ST_CHK_HIGH = 2'd1,
        ST_HIGH     = 2'd2,
        ST_CHK_LOW  = 2'd3
    } state_t;

    // Last count value of a check window; reaching it with din_s still at the
    // new level completes the window.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic            din_s;
    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            dout_q, dout_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
    logic            busy_q, busy_d;

`ifdef DEBOUNCE_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer: sync_q[0] may go metastable, sync_q[1] feeds the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], din};
        end
    end

    assign din_s = sync_q[1];
`else
    logic sync_q;

    // Single input register for a din already in the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 1'b0;
        end else begin
            sync_q <= din;
        end
    end

    assign din_s = sync_q;
`endif

    // Next-state, counter and output decode; outputs are derived from the
    // next state so the registered outputs line up with the state register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_LOW: begin
                if (din_s) begin
                    state_d = ST_CHK_HIGH;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_CHK_HIGH: begin
                if (!din_s) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (!din_s) begin
                    state_d = ST_CHK_LOW;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_CHK_LOW: begin
                if (din_s) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
            end
        endcase
        dout_d = (state_d == ST_HIGH) || (state_d == ST_CHK_LOW);
        busy_d = (state_d == ST_CHK_HIGH) || (state_d == ST_CHK_LOW);
    end

    // State, counter and output registers; reset abandons any check silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = busy_q;

endmodule

// File: doc/debounce_edge.md
DEBOUNCE_EDGE -- requirements
Module: debounce_edge

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, meaning the number of consecutive FSM samples at a new level required before dout follows it; legal range 2..65535.
REQ-002 Parameter CNT_W, default 16, meaning the stability counter width; it SHALL satisfy 2**CNT_W > STABLE_CYCLES.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge of clk only.
REQ-004 rst  input  1  reset; one clock, reset synchronous and active-high.
REQ-005 din  input  1  raw, asynchronous, possibly bouncing input level.
REQ-006 dout  output  1  debounced level; it feeds the din of the downstream flop stage.
REQ-007 rise  output  1  one-cycle pulse in the same cycle dout goes 0->1.
REQ-008 fall  output  1  one-cycle pulse in the same cycle dout goes 1->0.
REQ-009 busy  output  1  high while the FSM is in CHK_HIGH or CHK_LOW.

Function
REQ-010 din SHALL pass through N input registers (N defined in Configuration) to form din_s, the only value the FSM samples.
REQ-011 FSM states SHALL be LOW, CHK_HIGH, HIGH and CHK_LOW; dout=0 in LOW/CHK_HIGH and dout=1 in HIGH/CHK_LOW, all outputs registered.
REQ-012 LOW: din_s=1 -> CHK_HIGH with cnt=1; otherwise stay in LOW with cnt=0.
REQ-013 CHK_HIGH: din_s=0 -> LOW with cnt=0 and no pulse; else if cnt==STABLE_CYCLES-1 -> HIGH with rise=1 for exactly one cycle; else cnt+1.
REQ-014 HIGH and CHK_LOW SHALL mirror LOW and CHK_HIGH with levels inverted; reaching LOW from CHK_LOW SHALL assert fall=1 for one cycle.
REQ-015 Latency: dout SHALL update on rising edge number STABLE_CYCLES+N-1 after edge 0, where edge 0 is the first edge that samples din at the new level and din holds that level throughout.
REQ-016 A glitch shorter than the check window SHALL leave dout, rise and fall unchanged and return the FSM to its stable state.
REQ-017 rise and fall SHALL never be high in the same cycle, and SHALL never be high in two consecutive cycles.
REQ-018 cnt SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.

Reset
REQ-019 While rst=1 at a rising edge, the FSM SHALL go to LOW, and cnt, all input registers, dout, rise, fall and busy SHALL all become 0.
REQ-020 rst SHALL take priority over every transition; a reset asserted during CHK_* SHALL abandon the check with no pulse.
REQ-021 After rst deasserts with din=1, the block SHALL run a full CHK_HIGH window and then pulse rise.

Configuration
REQ-022 Macro DEBOUNCE_SYNC_EN defined: N=2, a two-flop synchronizer for an asynchronous din.
REQ-023 DEBOUNCE_SYNC_EN undefined: N=1, a single register for an already-synchronous din; all other behaviour SHALL be identical.

Verification (STABLE_CYCLES=4, DEBOUNCE_SYNC_EN defined, 10 ns clk)
REQ-024 rst=1 for 2 cycles with din=1 -> dout=rise=fall=busy=0 during reset.
REQ-025 After reset, din 0->1 held high, sampled at edge 0 -> dout=1 and rise=1 after edge 5; rise=0 after edge 6.
REQ-026 In HIGH, din 1->0 held low -> dout=0 and fall=1 after edge 5; fall pulses once.
REQ-027 In LOW, din high for 2 cycles, then low -> busy pulses, dout stays 0, and no rise occurs.
REQ-028 rst=1 during CHK_HIGH (cnt=2) -> next state LOW, no rise; release with din=1 -> rise 5 edges after release (edge 0 = the first edge with rst=0).
REQ-029 Rebuild without DEBOUNCE_SYNC_EN and repeat REQ-025 -> dout=1 after edge 4.
